// File: rtl/bram_stream_reader.sv
// Streams a window of words out of a block-RAM read port as a valid/ready
// stream. A 2-entry output FIFO decouples the one-cycle RAM read latency from
// downstream backpressure; reads are issued only when the FIFO is guaranteed
// to have room for the returning word.
module bram_stream_reader #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_ce,
  output logic              o_bram_we,
  output logic [DATA_W-1:0] o_bram_din,
  input  logic [DATA_W-1:0] i_bram_dout,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              i_tready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LEN_W-1:0]    remaining_reg, remaining_next;
  logic                inflight_reg;
  logic                inflight_last_reg;
  logic [DATA_W-1:0]   fifo_data_reg [2];
  logic                fifo_last_reg [2];
  logic                wr_ptr_reg;
  logic                rd_ptr_reg;
  logic [1:0]          count_reg;

  logic                issue;
  logic                push;
  logic                pop;
  logic [2:0]          occupancy;
  logic [LEN_W-1:0]    len_clamped;

  // Windows longer than the RAM are clamped to one full pass.
  assign len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;

  // Words in the FIFO plus the one possibly still coming back from the RAM.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign push      = inflight_reg;
  assign o_tvalid  = (count_reg != 2'd0);
  assign pop       = o_tvalid & i_tready;

  assign o_tdata     = fifo_data_reg[rd_ptr_reg];
  assign o_tlast     = fifo_last_reg[rd_ptr_reg] & o_tvalid;
  assign o_bram_ce   = issue;
  assign o_bram_addr = addr_reg;
  assign o_bram_we   = 1'b0;
  assign o_bram_din  = '0;
  assign o_busy      = (state_reg == ST_READ) || (state_reg == ST_DRAIN);
  assign o_done      = (state_reg == ST_DONE);

  // Next-state, read-issue and address/length bookkeeping.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    issue          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          addr_next      = i_base_addr;
          remaining_next = len_clamped;
          state_next     = (len_clamped == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        // A same-cycle pop frees a slot, so a full FIFO can still take a read.
        if ((remaining_reg != '0) && (occupancy < (3'd2 + {2'b00, pop}))) begin
          issue          = 1'b1;
          addr_next      = addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final beat handshakes so done follows directly.
        if (!inflight_reg && ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop))) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control registers: FSM state, read address, remaining count, in-flight tag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg         <= ST_IDLE;
      addr_reg          <= '0;
      remaining_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      remaining_reg     <= remaining_next;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (remaining_reg == LEN_W'(1));
    end
  end

  // Output FIFO: capture returning RAM data only when a read is in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_last_reg[i] <= 1'b0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= i_bram_dout;
        fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed testbench for bram_stream_reader with a behavioural RAM that drives
// junk on its data port whenever no read was issued the previous cycle.
module tb_bram_stream_reader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_base_addr = '0;
  logic [8:0]  i_len = '0;
  logic        o_busy, o_done, o_bram_ce, o_bram_we;
  logic [7:0]  o_bram_addr;
  logic [23:0] o_bram_din;
  logic [23:0] i_bram_dout = '0;
  logic [23:0] o_tdata;
  logic        o_tvalid, o_tlast;
  logic        i_tready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [23:0] mem [256];

  logic [23:0] beat_data [$];
  logic        beat_last [$];
  int first_valid, done_cycle, last_hs, done_count;
  int stall_err, ovf_err, addr_err, ce_count;
  logic busy_at_done;

  bram_stream_reader #(.DATA_W(24), .ADDR_W(8), .LEN_W(9)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done),
    .o_bram_addr(o_bram_addr), .o_bram_ce(o_bram_ce),
    .o_bram_we(o_bram_we), .o_bram_din(o_bram_din),
    .i_bram_dout(i_bram_dout),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .i_tready(i_tready)
  );

  always #5 i_clk = ~i_clk;

  // RAM port model: one-cycle read latency, junk when not enabled.
  always @(posedge i_clk) begin
    if (o_bram_ce) i_bram_dout <= mem[o_bram_addr];
    else           i_bram_dout <= 24'hDEAD00;
  end

  // Drives one transfer and records what came out; the caller does the checks.
  task automatic run_stream(input logic [7:0] base, input logic [8:0] len, input int mode,
                            input int inj_cycle, input logic [7:0] inj_base, input int budget);
    int   occ_before;
    int   issued;
    bit   hs;
    bit   prev_stall;
    logic [23:0] prev_data;
    logic prev_last;
    beat_data.delete();
    beat_last.delete();
    first_valid = -1; done_cycle = -1; last_hs = -1; done_count = 0;
    stall_err = 0; ovf_err = 0; addr_err = 0; ce_count = 0; busy_at_done = 1'b1;
    occ_before = 0; issued = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      i_start     = (c == 0) || (c == inj_cycle);
      i_base_addr = (c == inj_cycle) ? inj_base : base;
      i_len       = (c == inj_cycle) ? 9'd5 : len;
      i_tready    = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      hs = o_tvalid && i_tready;
      if (o_tvalid && first_valid < 0) first_valid = c;
      if (prev_stall && (!o_tvalid || o_tdata !== prev_data || o_tlast !== prev_last)) stall_err++;
      prev_stall = o_tvalid && !i_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      if (o_bram_ce) begin
        if (occ_before >= 2 && !hs) ovf_err++;
        if (o_bram_addr !== base + 8'(issued)) addr_err++;
        issued++;
        ce_count++;
      end
      if (hs) begin
        beat_data.push_back(o_tdata);
        beat_last.push_back(o_tlast);
        last_hs = c;
      end
      if (o_done) begin
        done_count++;
        if (done_cycle < 0) begin
          done_cycle   = c;
          busy_at_done = o_busy;
        end
      end
      occ_before = occ_before + (o_bram_ce ? 1 : 0) - (hs ? 1 : 0);
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
    i_start = 1'b0;
    $display("transfer base=%h len=%0d beats=%0d first_valid=%0d last_hs=%0d done=%0d",
             base, len, beat_data.size(), first_valid, last_hs, done_cycle);
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_bram_ce !== 1'b0)   begin errors++; $display("FAIL reset_ce got %b want 0", o_bram_ce); end
    checks++; if (o_bram_addr !== 8'h0) begin errors++; $display("FAIL reset_addr got %h want 00", o_bram_addr); end
    checks++; if (o_tvalid !== 1'b0)    begin errors++; $display("FAIL reset_tvalid got %b want 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0)     begin errors++; $display("FAIL reset_tlast got %b want 0", o_tlast); end
    checks++; if (o_tdata !== 24'h0)    begin errors++; $display("FAIL reset_tdata got %h want 000000", o_tdata); end
    checks++; if (o_bram_we !== 1'b0 || o_bram_din !== 24'h0) begin
      errors++; $display("FAIL reset_we_din got %b/%h want 0/000000", o_bram_we, o_bram_din); end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_basic();
    run_stream(8'h10, 9'd4, 0, -1, 8'h00, 40);
    checks++; if (beat_data.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", beat_data.size()); end
    for (int k = 0; k < beat_data.size() && k < 4; k++) begin
      checks++; if (beat_data[k] !== 24'h100010 + 24'(k)) begin
        errors++; $display("FAIL basic_data[%0d] got %h want %h", k, beat_data[k], 24'h100010 + 24'(k)); end
      checks++; if (beat_last[k] !== (k == 3)) begin
        errors++; $display("FAIL basic_last[%0d] got %b want %b", k, beat_last[k], (k == 3)); end
    end
    checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", first_valid); end
    checks++; if (last_hs != 6) begin errors++; $display("FAIL basic_consecutive last beat cycle %0d want 6", last_hs); end
    checks++; if (done_cycle != 7) begin errors++; $display("FAIL basic_done_cycle got %0d want 7", done_cycle); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy_at_done); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_count); end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_w [4];
    exp_w[0] = 24'h1000FE; exp_w[1] = 24'h1000FF; exp_w[2] = 24'h100000; exp_w[3] = 24'h100001;
    run_stream(8'hFE, 9'd4, 0, -1, 8'h00, 40);
    checks++; if (beat_data.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", beat_data.size()); end
    for (int k = 0; k < beat_data.size() && k < 4; k++) begin
      checks++; if (beat_data[k] !== exp_w[k]) begin
        errors++; $display("FAIL wrap_data[%0d] got %h want %h", k, beat_data[k], exp_w[k]); end
    end
    checks++; if (addr_err != 0) begin errors++; $display("FAIL wrap_addr bad addresses %0d want 0", addr_err); end
  endtask

  task automatic test_backpressure();
    logic [7:0] a;
    int bad;
    for (int rep = 0; rep < 3; rep++) begin
      run_stream(8'h40 + 8'(rep * 16), 9'd8, 1, -1, 8'h00, 300);
      bad = 0;
      for (int k = 0; k < beat_data.size(); k++) begin
        a = 8'h40 + 8'(rep * 16) + 8'(k);
        if (beat_data[k] !== {16'h1000, a} || beat_last[k] !== (k == 7)) bad++;
      end
      checks++; if (beat_data.size() != 8) begin errors++; $display("FAIL bp_count rep%0d got %0d want 8", rep, beat_data.size()); end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_order rep%0d wrong beats %0d want 0", rep, bad); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable rep%0d changes while stalled %0d want 0", rep, stall_err); end
      checks++; if (ovf_err != 0) begin errors++; $display("FAIL bp_issue rep%0d reads into full buffer %0d want 0", rep, ovf_err); end
      checks++; if (ce_count != 8) begin errors++; $display("FAIL bp_reads rep%0d got %0d want 8", rep, ce_count); end
      checks++; if (done_cycle != last_hs + 1) begin
        errors++; $display("FAIL bp_done rep%0d done at %0d want %0d", rep, done_cycle, last_hs + 1); end
    end
  endtask

  task automatic test_edge_lengths();
    int bad;
    int nlast;
    run_stream(8'h33, 9'd0, 0, -1, 8'h00, 20);
    checks++; if (beat_data.size() != 0 || first_valid != -1) begin
      errors++; $display("FAIL len0_beats got %0d beats want 0", beat_data.size()); end
    checks++; if (ce_count != 0) begin errors++; $display("FAIL len0_reads got %0d want 0", ce_count); end
    checks++; if (done_cycle != 1) begin errors++; $display("FAIL len0_done got %0d want 1", done_cycle); end

    run_stream(8'h20, 9'd300, 0, -1, 8'h00, 400);
    bad = 0; nlast = 0;
    for (int k = 0; k < beat_data.size(); k++) begin
      if (beat_data[k] !== {16'h1000, 8'h20 + 8'(k)}) bad++;
      if (beat_last[k]) nlast++;
    end
    checks++; if (beat_data.size() != 256) begin errors++; $display("FAIL len300_count got %0d want 256", beat_data.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL len300_data wrong beats %0d want 0", bad); end
    checks++; if (beat_data.size() > 0 && (beat_data[$] !== 24'h10001F || beat_last[$] !== 1'b1 || nlast != 1)) begin
      errors++; $display("FAIL len300_last got %h last=%b nlast=%0d want 10001f 1 1", beat_data[$], beat_last[$], nlast); end
    checks++; if (ce_count != 256) begin errors++; $display("FAIL len300_reads got %0d want 256", ce_count); end
  endtask

  task automatic test_start_while_busy();
    int bad;
    run_stream(8'h80, 9'd6, 0, 4, 8'h05, 60);
    bad = 0;
    for (int k = 0; k < beat_data.size(); k++)
      if (beat_data[k] !== 24'h100080 + 24'(k) || beat_last[k] !== (k == 5)) bad++;
    checks++; if (beat_data.size() != 6) begin errors++; $display("FAIL busy_start_count got %0d want 6", beat_data.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_start_data wrong beats %0d want 0", bad); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL busy_start_done got %0d pulses want 1", done_count); end
  endtask

  task automatic test_reset_mid();
    int nb;
    int bad;
    nb = 0;
    i_tready = 1'b1;
    for (int c = 0; c < 60 && nb < 2; c++) begin
      @(negedge i_clk);
      i_start = (c == 0); i_base_addr = 8'h50; i_len = 9'd10;
      #1;
      if (o_tvalid && i_tready) nb++;
    end
    checks++; if (nb != 2) begin errors++; $display("FAIL rstmid_progress got %0d beats want 2", nb); end
    @(negedge i_clk);
    i_start = 1'b0;
    i_rst = 1'b0;
    #1;
    checks++; if ({o_busy, o_done, o_bram_ce, o_tvalid, o_tlast} !== 5'b0 || o_bram_addr !== 8'h0 || o_tdata !== 24'h0) begin
      errors++; $display("FAIL rstmid_outputs got busy%b done%b ce%b v%b l%b a%h d%h want all 0",
                         o_busy, o_done, o_bram_ce, o_tvalid, o_tlast, o_bram_addr, o_tdata); end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk); #1;
      if (o_done || o_tvalid || o_busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_hold activity cycles %0d want 0", bad); end
    @(negedge i_clk);
    i_rst = 1'b1;
    run_stream(8'h70, 9'd3, 0, -1, 8'h00, 40);
    bad = 0;
    for (int k = 0; k < beat_data.size(); k++)
      if (beat_data[k] !== 24'h100070 + 24'(k) || beat_last[k] !== (k == 2)) bad++;
    checks++; if (beat_data.size() != 3 || bad != 0) begin
      errors++; $display("FAIL rstmid_restart got %0d beats %0d wrong want 3 0", beat_data.size(), bad); end
    checks++; if (first_valid != 3 || done_count != 1) begin
      errors++; $display("FAIL rstmid_restart_timing first_valid %0d done %0d want 3 1", first_valid, done_count); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 24'h100000 + 24'(a);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge_lengths();
    test_start_while_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side companion of the 256x24 single-clock dual-port block RAM. On a start pulse it sequentially reads a window of words through one RAM port, which has one-cycle read latency. It delivers the words as a valid/ready stream with a last marker to the downstream consumer (serial/front-panel link). The stream supports full backpressure without losing or duplicating words.

Parameters:
DATA_W, 24, RAM word width
ADDR_W, 8, RAM address width; depth = 2**ADDR_W
LEN_W, 9, width of length input; must cover 0..2**ADDR_W

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle start pulse; ignored unless idle
i_base_addr  in  ADDR_W  first address of window, sampled with i_start
i_len  in  LEN_W  word count, sampled with i_start
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle pulse at transfer end
o_bram_addr  out  ADDR_W  RAM port address
o_bram_ce  out  1  RAM port enable (one read issued per high cycle)
o_bram_we  out  1  constant 0
o_bram_din  out  DATA_W  constant 0
i_bram_dout  in  DATA_W  RAM port registered read data
o_tdata  out  DATA_W  stream data
o_tvalid  out  1  stream valid
o_tlast  out  1  marks final word of window
i_tready  in  1  downstream ready

Behaviour:
- Reset (async, i_rst=0): FSM=IDLE; all counters, FIFO and flags cleared. Reset values: o_busy=0, o_done=0, o_bram_ce=0, o_bram_addr=0, o_tvalid=0, o_tlast=0, o_tdata=0. Reset mid-transfer aborts it with no done pulse.
- Length rule: i_len=0 -> no reads, no beats, o_done pulses the cycle after start. i_len>2**ADDR_W -> clamped to 2**ADDR_W.
- Address rule: word k is read from (i_base_addr+k) mod 2**ADDR_W. The window wraps 255->0.
- FSM states:
  - IDLE: i_start=1 latches base and len, then goes to READ (or DONE if len=0).
  - READ: issues reads until len reads have been issued, then goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then goes to DONE.
  - DONE: one cycle, o_done=1, then IDLE.
- o_busy=1 in READ and DRAIN, 0 in IDLE and DONE. An i_start in any non-IDLE state is ignored.
- Read issue: o_bram_ce=1 with o_bram_addr registered. Data for a read issued in cycle t appears on i_bram_dout in cycle t+1. A registered in-flight flag captures it into the FIFO at the end of t+1.
- Output buffer: 2-entry FIFO; head drives o_tdata/o_tvalid/o_tlast. The beat completes on o_tvalid & i_tready.
- Issue condition in READ: reads remaining > 0 and (fifo_count + inflight - pop) < 2, where pop = o_tvalid & i_tready this cycle. This guarantees no FIFO overflow and sustains 1 word/cycle with i_tready held high.
- When no read is issued, o_bram_ce=0 and o_bram_addr holds its value. Data shown on i_bram_dout while no read is in flight is never captured.
- o_tlast=1 only on the FIFO entry that carries word len-1 (tagged at capture).
- o_tdata/o_tlast are stable while o_tvalid=1 and i_tready=0.
- Latency: i_start sampled at edge E0 -> first read in cycle C1 -> first o_tvalid in C3.
- o_done pulses in the cycle after the handshake of the last beat. o_busy falls in the same cycle.
- Simultaneous push and pop on the FIFO is legal at any count, including 2. Count is unchanged in that case.

Test Plan:
- RAM preloaded with word[a]=0x100000+a. Start base=0x10, len=4, i_tready=1 -> beats 0x100010..0x100013 on consecutive cycles, first o_tvalid 3 cycles after start. o_tlast on 0x100013; o_done one cycle later.
- Wrap: base=0xFE, len=4 -> addresses FE, FF, 00, 01 -> data 0x1000FE, 0x1000FF, 0x100000, 0x100001.
- Backpressure: len=8, i_tready random 50% -> exactly 8 beats in order, no duplicates or drops. o_tdata stable while stalled. o_bram_ce never issues when FIFO+inflight=2 without a pop.
- Edge lengths: len=0 -> no o_tvalid, o_done next cycle. len=300 -> exactly 256 beats, last=word base-1.
- Start while busy: second i_start mid-transfer with different base -> ignored, original sequence completes unchanged.
- Reset mid-transfer: i_rst low during beat 3 of len=10 -> all outputs 0 immediately, no o_done. A new start after reset runs a clean transfer.
